niosii_system_sysid_regs: RTL and testbench



---
 rtl/niosii_system_sysid_regs_pkg.sv | 51 +++++
 rtl/niosii_system_sysid_uptime.sv | 56 +++++
 rtl/niosii_system_sysid_regs.sv | 109 ++++++++++
 tb/tb_niosii_system_sysid_regs.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/niosii_system_sysid_regs_pkg.sv
// Shared constants, CTRL command payload and helpers for the system-ID register block.
package niosii_system_sysid_regs_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned BE_W   = DATA_W / 8;

    localparam logic [ADDR_W-1:0] ADDR_ID           = 4'd0;
    localparam logic [ADDR_W-1:0] ADDR_TIMESTAMP    = 4'd1;
    localparam logic [ADDR_W-1:0] ADDR_UPTIME_LO    = 4'd2;
    localparam logic [ADDR_W-1:0] ADDR_UPTIME_HI    = 4'd3;
    localparam logic [ADDR_W-1:0] ADDR_CTRL         = 4'd4;
    localparam logic [ADDR_W-1:0] ADDR_SCRATCH_BASE = 4'd8;

    localparam int unsigned CTRL_EN_BIT  = 0;
    localparam int unsigned CTRL_CLR_BIT = 1;
    localparam int unsigned CTRL_OVF_BIT = 2;

    localparam int unsigned NUM_SCRATCH_MIN = 1;
    localparam int unsigned NUM_SCRATCH_MAX = 8;
    localparam int unsigned UPTIME_W_MIN    = 33;
    localparam int unsigned UPTIME_W_MAX    = 64;

    // Decoded CTRL write, already qualified by address and lane 0.
    typedef struct packed {
        logic we;
        logic en;
        logic clr;
        logic ovf_clr;
    } ctrl_cmd_t;

    function automatic logic [ADDR_W-1:0] scratch_addr(input int unsigned idx);
        return ADDR_SCRATCH_BASE + ADDR_W'(idx);
    endfunction

    function automatic logic [DATA_W-1:0] byte_merge(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int unsigned b = 0; b < BE_W; b++) begin
            if (be[b]) begin
                res[b*8 +: 8] = new_word[b*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/niosii_system_sysid_uptime.sv
// Free-running uptime counter with enable, synchronous clear and sticky overflow flag.
module niosii_system_sysid_uptime
    import niosii_system_sysid_regs_pkg::*;
#(
    parameter int unsigned UPTIME_W = 48
) (
    input  logic                clock,
    input  logic                reset_n,
    input  ctrl_cmd_t           ctrl_cmd,
    output logic [UPTIME_W-1:0] count,
    output logic                en,
    output logic                ovf
);

    logic [UPTIME_W-1:0] count_nxt_c;
    logic                en_nxt_c;
    logic                ovf_nxt_c;
    logic                wrap_c;

    // Clear beats increment; a wrap masked by clear never flags overflow; set beats W1C.
    always_comb begin
        count_nxt_c = count;
        en_nxt_c    = en;
        ovf_nxt_c   = ovf;
        wrap_c      = 1'b0;
        if (en) begin
            count_nxt_c = count + UPTIME_W'(1);
            wrap_c      = (count == '1);
        end
        if (ctrl_cmd.clr) begin
            count_nxt_c = '0;
        end
        if (ctrl_cmd.we) begin
            en_nxt_c = ctrl_cmd.en;
        end
        if (ctrl_cmd.ovf_clr) begin
            ovf_nxt_c = 1'b0;
        end
        if (wrap_c && !ctrl_cmd.clr) begin
            ovf_nxt_c = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count <= '0;
            en    <= 1'b1;
            ovf   <= 1'b0;
        end else begin
            count <= count_nxt_c;
            en    <= en_nxt_c;
            ovf   <= ovf_nxt_c;
        end
    end

endmodule

// File: rtl/niosii_system_sysid_regs.sv
// Avalon-MM system-ID slave: ID/timestamp words, latched uptime counter, CTRL and scratch.
module niosii_system_sysid_regs
    import niosii_system_sysid_regs_pkg::*;
#(
    parameter logic [31:0] ID_VALUE      = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP     = 32'h0000_0000,
    parameter int unsigned NUM_SCRATCH   = 2,
    parameter logic [31:0] SCRATCH_RESET = 32'h0000_0000,
    parameter int unsigned UPTIME_W      = 48
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [DATA_W-1:0] writedata,
    input  logic [BE_W-1:0]   byteenable,
    output logic [DATA_W-1:0] readdata,
    output logic              readdatavalid
);

    if (NUM_SCRATCH < NUM_SCRATCH_MIN || NUM_SCRATCH > NUM_SCRATCH_MAX) begin : g_bad_num_scratch
        $error("NUM_SCRATCH out of legal range");
    end
    if (UPTIME_W < UPTIME_W_MIN || UPTIME_W > UPTIME_W_MAX) begin : g_bad_uptime_w
        $error("UPTIME_W out of legal range");
    end

    ctrl_cmd_t           ctrl_cmd;
    logic [UPTIME_W-1:0] count;
    logic                en;
    logic                ovf;
    logic [DATA_W-1:0]   shadow;
    logic [DATA_W-1:0]   scratch [NUM_SCRATCH];
    logic [DATA_W-1:0]   rd_data_c;
    logic                read_fire;

    // A write always wins over a coincident read.
    assign read_fire = read && !write;

    always_comb begin
        ctrl_cmd         = '0;
        ctrl_cmd.we      = write && (address == ADDR_CTRL) && byteenable[0];
        ctrl_cmd.en      = writedata[CTRL_EN_BIT];
        ctrl_cmd.clr     = ctrl_cmd.we && writedata[CTRL_CLR_BIT];
        ctrl_cmd.ovf_clr = ctrl_cmd.we && writedata[CTRL_OVF_BIT];
    end

    niosii_system_sysid_uptime #(
        .UPTIME_W (UPTIME_W)
    ) u_uptime (
        .clock    (clock),
        .reset_n  (reset_n),
        .ctrl_cmd (ctrl_cmd),
        .count    (count),
        .en       (en),
        .ovf      (ovf)
    );

    always_comb begin
        rd_data_c = '0;
        case (address)
            ADDR_ID:        rd_data_c = ID_VALUE;
            ADDR_TIMESTAMP: rd_data_c = TIMESTAMP;
            ADDR_UPTIME_LO: rd_data_c = count[31:0];
            ADDR_UPTIME_HI: rd_data_c = shadow;
            ADDR_CTRL: begin
                rd_data_c[CTRL_EN_BIT]  = en;
                rd_data_c[CTRL_OVF_BIT] = ovf;
            end
            default: begin
                for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
                    if (address == scratch_addr(i)) begin
                        rd_data_c = scratch[i];
                    end
                end
            end
        endcase
    end

    // Scratch words honour byte lanes; unmapped scratch addresses fall through untouched.
    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
            if (!reset_n) begin
                scratch[i] <= SCRATCH_RESET;
            end else if (write && (address == scratch_addr(i))) begin
                scratch[i] <= byte_merge(scratch[i], writedata, byteenable);
            end
        end
    end

    // Reading UPTIME_LO snapshots the upper counter bits so HI pairs with that LO.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            readdata      <= '0;
            readdatavalid <= 1'b0;
            shadow        <= '0;
        end else begin
            readdatavalid <= read_fire;
            if (read_fire) begin
                readdata <= rd_data_c;
                if (address == ADDR_UPTIME_LO) begin
                    shadow <= 32'(count[UPTIME_W-1:32]);
                end
            end
        end
    end

endmodule

// File: tb/tb_niosii_system_sysid_regs.sv
// Directed bench for the system-ID register block with a queue-based read scoreboard.
module tb_niosii_system_sysid_regs;

    localparam logic [31:0] ID_V = 32'h58B4_7169;
    localparam logic [31:0] TS_V = 32'h6650_A1C0;

    logic        clock;
    logic        reset_n;
    logic [3:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        readdatavalid;

    niosii_system_sysid_regs #(
        .ID_VALUE      (ID_V),
        .TIMESTAMP     (TS_V),
        .NUM_SCRATCH   (2),
        .SCRATCH_RESET (32'h0000_0000),
        .UPTIME_W      (33)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .readdata      (readdata),
        .readdatavalid (readdatavalid)
    );

    typedef struct {
        logic [31:0] data;
        int          due;
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 0;
    bit          rst_at_edge = 1;
    bit          exp_v;
    logic [31:0] last_exp = '0;
    string       cur_name;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) begin
        cyc         <= cyc + 1;
        rst_at_edge <= !reset_n;
    end

    // Monitor: every cycle, readdatavalid must match the scoreboard and readdata must hold otherwise.
    always @(negedge clock) begin
        if (mon_en) begin
            exp_v    = (sb.size() > 0) && (sb[0].due == cyc);
            cur_name = "hold";
            if (exp_v) begin
                e        = sb.pop_front();
                last_exp = e.data;
                cur_name = e.name;
            end
            if (rst_at_edge) begin
                last_exp = '0;
            end
            checks++;
            if (readdatavalid !== exp_v) begin
                errors++;
                $display("FAIL rdv(%s) cyc=%0d got=%0b exp=%0b", cur_name, cyc, readdatavalid, exp_v);
            end
            checks++;
            if (readdata !== last_exp) begin
                errors++;
                $display("FAIL %s cyc=%0d got=%h exp=%h", cur_name, cyc, readdata, last_exp);
            end
        end
    end

    task automatic step();
        @(negedge clock);
    endtask

    task automatic idle();
        read       = 1'b0;
        write      = 1'b0;
        address    = 4'd0;
        writedata  = 32'd0;
        byteenable = 4'd0;
    endtask

    task automatic set_rd(input logic [3:0] a, input logic [31:0] d, input string n);
        exp_t x;
        read    = 1'b1;
        write   = 1'b0;
        address = a;
        x.data  = d;
        x.due   = cyc + 1;
        x.name  = n;
        sb.push_back(x);
    endtask

    task automatic set_rd_drop(input logic [3:0] a);
        read    = 1'b1;
        write   = 1'b0;
        address = a;
    endtask

    task automatic set_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        read       = 1'b0;
        write      = 1'b1;
        address    = a;
        writedata  = d;
        byteenable = be;
    endtask

    task automatic set_rw(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        set_wr(a, d, be);
        read = 1'b1;
    endtask

    task automatic preload(input logic [32:0] v);
        force dut.u_uptime.count = v;
        #1;
        release dut.u_uptime.count;
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        repeat (3) step();
        mon_en = 1;

        // Reset values; counter starts on first edge out of reset
        step(); reset_n = 1'b1; set_rd(4'd2, 32'd0, "lo_first");
        step(); set_rd(4'd2, 32'd1, "lo_second");
        step(); set_rd(4'd0, ID_V, "id");
        step(); set_rd(4'd1, TS_V, "timestamp");
        step(); set_rd(4'd3, 32'd0, "hi_reset");
        step(); set_rd(4'd4, 32'h1, "ctrl_reset");
        step(); set_rd(4'd8, 32'd0, "scr0_reset");
        step(); idle();

        // Scratch byte lanes and unmapped addresses
        step(); set_wr(4'd8, 32'hFFFF_FFFF, 4'b0101);
        step(); set_rd(4'd8, 32'h00FF_00FF, "scr0_lanes");
        step(); set_wr(4'd12, 32'hDEAD_BEEF, 4'hF);
        step(); set_rd(4'd12, 32'd0, "addr12");
        step(); set_wr(4'd9, 32'hA5A5_1234, 4'hF);
        step(); set_rd(4'd9, 32'hA5A5_1234, "scr1");
        step(); set_rd(4'd15, 32'd0, "addr15");
        step(); set_wr(4'd4, 32'h0, 4'b1110);
        step(); set_rd(4'd4, 32'h1, "ctrl_lane0_off");
        step(); idle();

        // Shadow latch: LO at 0x1_0000_0005
        step(); idle(); preload(33'h1_0000_0004);
        step(); set_rd(4'd2, 32'h0000_0005, "lo_latch");
        step(); set_rd(4'd3, 32'h0000_0001, "hi_latch");
        step(); idle();

        // Full wrap: OVF set, shadow stable, W1C
        step(); idle(); preload(33'h1_FFFF_FFFD);
        step();
        step();
        step(); set_rd(4'd3, 32'h0000_0001, "hi_after_wrap");
        step(); set_rd(4'd4, 32'h5, "ctrl_ovf");
        step(); set_wr(4'd4, 32'h5, 4'b0001);
        step(); set_rd(4'd4, 32'h1, "ctrl_w1c");
        step(); set_rd(4'd2, 32'd4, "lo_after_wrap");
        step(); idle();

        // CLR on wrap edge suppresses OVF
        step(); idle(); preload(33'h1_FFFF_FFFE);
        step(); set_wr(4'd4, 32'h3, 4'b0001);
        step(); set_rd(4'd4, 32'h1, "ctrl_clr_wrap");
        step(); set_rd(4'd2, 32'd1, "lo_after_clr");
        step(); set_wr(4'd4, 32'h0, 4'b0001);
        step(); idle();
        repeat (10) step();
        set_rd(4'd2, 32'd3, "lo_frozen");
        step(); set_rd(4'd4, 32'h0, "ctrl_dis");
        step(); set_wr(4'd4, 32'h1, 4'b0001);
        step(); set_rd(4'd2, 32'd3, "lo_reen_edge");
        step(); set_rd(4'd2, 32'd4, "lo_running");
        step(); idle();

        // Read+write together: write only, no readdatavalid
        step(); set_rw(4'd8, 32'h1234_5678, 4'hF);
        step(); set_rw(4'd4, 32'h1, 4'b0001);
        step(); set_rd(4'd8, 32'h1234_5678, "scr0_rw");
        step(); idle();

        // Reset during a read: dropped, everything back to reset values
        step(); idle(); preload(33'h1_0000_0004);
        step(); set_rd(4'd2, 32'h0000_0005, "lo_pre_rst");
        step(); reset_n = 1'b0; set_rd_drop(4'd2);
        step(); idle();
        step();
        step(); reset_n = 1'b1; set_rd(4'd2, 32'd0, "lo_post_rst");
        step(); set_rd(4'd2, 32'd1, "lo_post_rst2");
        step(); set_rd(4'd3, 32'd0, "hi_post_rst");
        step(); set_rd(4'd4, 32'h1, "ctrl_post_rst");
        step(); set_rd(4'd8, 32'd0, "scr0_post_rst");
        step(); set_rd(4'd9, 32'd0, "scr1_post_rst");
        step(); idle();
        repeat (3) step();

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got=%0d pending exp=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
